matrix_byte_loader: RTL and testbench

Byte-serial input stage that sits directly upstream of the 10x10 matrix multiplier. It accepts a stream of bytes over a valid/ready handshake, with all of A in row-major order followed by all of B. It packs them into the flattened 800-bit A and B buses and presents a complete operand pair with a valid/ready handshake. The multiplier (or its controller) consumes the pair. The loader then re-arms for the next pair.

---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_byte_loader.sv | 131 +++++++++++++
 tb/tb_matrix_byte_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the byte loader and the 10x10 multiplier.
package matrix_pkg;

   localparam int N        = 10;
   localparam int W        = 8;
   localparam int MAT_BITS = N * N * W;
   localparam int ELEMS    = N * N;

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      CHECK,
      HOLD
   } state_t;

endpackage

// File: rtl/matrix_byte_loader.sv
// Byte-serial loader packing row-major A then B into flattened operand buses.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module matrix_byte_loader
   import matrix_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [W-1:0]        in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [MAT_BITS-1:0] A,
   output logic [MAT_BITS-1:0] B,
   output logic                mat_valid,
   input  logic                mat_ready,
   output logic                err
);

   localparam logic [6:0] LAST_IDX = 7'(ELEMS - 1);

   state_t     state_q, state_d;
   logic [6:0] idx_q, idx_d;
   logic       accept;
   logic       last;

`ifdef LOADER_CHECKSUM_EN
   logic [W-1:0] sum_q;
   logic         err_q;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      in_ready  = (state_q != HOLD);
      mat_valid = (state_q == HOLD);
      accept    = in_valid && in_ready;
      last      = (idx_q == LAST_IDX);

      case (state_q)
         LOAD_A: begin
            if (accept) begin
               if (last) begin
                  idx_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         LOAD_B: begin
            if (accept) begin
               if (last) begin
                  idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = HOLD;
`endif
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) state_d = (in_data == sum_q) ? HOLD : LOAD_A;
         end
`endif
         HOLD: begin
            if (mat_ready) begin
               state_d = LOAD_A;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
      endcase

      // Flush outranks any accept or transfer in the same cycle
      if (clr) begin
         state_d = LOAD_A;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Operand registers survive clr; only rst or a fresh load overwrites them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A <= '0;
         B <= '0;
      end else if (!clr && accept) begin
         if (state_q == LOAD_A) A[int'(idx_q) * W +: W] <= in_data;
         if (state_q == LOAD_B) B[int'(idx_q) * W +: W] <= in_data;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else if (clr) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= accept && (state_q == CHECK) && (in_data != sum_q);
         if (accept) begin
            if (state_q == LOAD_A || state_q == LOAD_B) sum_q <= sum_q + in_data;
            else if (state_q == CHECK)                   sum_q <= '0;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_byte_loader.sv
// Directed scoreboard bench for matrix_byte_loader; adds checksum cases when LOADER_CHECKSUM_EN is defined.
module tb_matrix_byte_loader;
   import matrix_pkg::*;

   logic                clk = 1'b0;
   logic                rst, clr, in_valid, in_ready, mat_valid, mat_ready, err;
   logic [W-1:0]        in_data;
   logic [MAT_BITS-1:0] A, B;

   typedef struct packed {
      logic [MAT_BITS-1:0] a;
      logic [MAT_BITS-1:0] b;
   } pair_t;

   pair_t               sb[$];
   logic [MAT_BITS-1:0] exp_a, exp_b;
   int                  checks = 0;
   int                  errors = 0;
   int                  accepts = 0;

   matrix_byte_loader dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst && !clr && in_valid && in_ready) accepts++;

   task automatic chk_int(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [MAT_BITS-1:0] obs, input logic [MAT_BITS-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] stream_byte(input int i);
      if (i < ELEMS) return exp_a[i * W +: W];
      return exp_b[(i - ELEMS) * W +: W];
   endfunction

   task automatic put_byte(input logic [W-1:0] b, input bit gaps);
      if (gaps) begin
         while ($urandom_range(1) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && in_ready !== 1'b1; t++) begin
         @(posedge clk); #1;
      end
      if (in_ready !== 1'b1) chk_int("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic put_prefix(input int n);
      for (int i = 0; i < n; i++) put_byte(stream_byte(i), 1'b0);
      in_valid = 1'b0;
   endtask

   task automatic send_pair(input bit gaps, input logic [W-1:0] cks_off);
      int           a0;
      logic [W-1:0] sum;
      a0  = accepts;
      sum = '0;
      for (int i = 0; i < 2 * ELEMS; i++) begin
         sum = sum + stream_byte(i);
         put_byte(stream_byte(i), gaps);
`ifdef LOADER_CHECKSUM_EN
         chk_int("mat_valid_during_load", 32'(mat_valid), 32'd0);
`else
         chk_int("mat_valid_at_accept", 32'(mat_valid), 32'(i == 2 * ELEMS - 1));
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      put_byte(sum + cks_off, gaps);
      in_valid = 1'b0;
      if (cks_off == '0) begin
         chk_int("cks_ok_valid", 32'(mat_valid), 32'd1);
         chk_int("cks_ok_err", 32'(err), 32'd0);
         sb.push_back('{a: exp_a, b: exp_b});
      end else begin
         chk_int("cks_bad_err", 32'(err), 32'd1);
         chk_int("cks_bad_valid", 32'(mat_valid), 32'd0);
         chk_int("cks_bad_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         chk_int("cks_bad_err_pulse", 32'(err), 32'd0);
         chk_int("cks_bad_still_idle", 32'(mat_valid), 32'd0);
      end
      chk_int("accept_count", 32'(accepts - a0), 32'(2 * ELEMS + 1));
`else
      in_valid = 1'b0;
      chk_int("err_tied_low", 32'(err), 32'd0);
      chk_int("accept_count", 32'(accepts - a0), 32'(2 * ELEMS));
      sb.push_back('{a: exp_a, b: exp_b});
`endif
   endtask

   task automatic take_pair(input int hold);
      pair_t e;
      for (int t = 0; t < 10 && mat_valid !== 1'b1; t++) begin
         @(posedge clk); #1;
      end
      chk_int("mat_valid_wait", 32'(mat_valid), 32'd1);
      chk_int("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk_bus("A_at_present", A, e.a);
      chk_bus("B_at_present", B, e.b);
      // Offer junk bytes while held; loader must ignore them
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         in_data  = 8'hEE;
         @(posedge clk); #1;
         chk_bus("A_hold", A, e.a);
         chk_bus("B_hold", B, e.b);
         chk_int("in_ready_hold", 32'(in_ready), 32'd0);
         chk_int("mat_valid_hold", 32'(mat_valid), 32'd1);
      end
      in_valid  = 1'b0;
      mat_ready = 1'b1;
      @(posedge clk); #1;
      mat_ready = 1'b0;
      chk_int("mat_valid_after_xfer", 32'(mat_valid), 32'd0);
      chk_int("in_ready_after_xfer", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_int({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk_int({tag, "_mat_valid"}, 32'(mat_valid), 32'd0);
      chk_int({tag, "_err"}, 32'(err), 32'd0);
      chk_bus({tag, "_A"}, A, '0);
      chk_bus({tag, "_B"}, B, '0);
   endtask

   task automatic fill_random;
      for (int i = 0; i < ELEMS; i++) begin
         exp_a[i * W +: W] = W'($urandom_range(255));
         exp_b[i * W +: W] = W'($urandom_range(255));
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; mat_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Ramp A, all-ones B, continuous valid, long hold
      for (int i = 0; i < ELEMS; i++) begin
         exp_a[i * W +: W] = W'(i + 1);
         exp_b[i * W +: W] = 8'd1;
      end
      send_pair(1'b0, 8'd0);
      chk_int("A_first_byte", 32'(A[7:0]), 32'd1);
      chk_int("A_last_byte", 32'(A[MAT_BITS-1 -: W]), 32'd100);
      take_pair(20);

      // Same data with ragged in_valid, minimum hold
      send_pair(1'b1, 8'd0);
      take_pair(0);

      // Flush after 150 accepts, then a full new pair
      fill_random();
      put_prefix(150);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk_int("clr_mat_valid", 32'(mat_valid), 32'd0);
      chk_int("clr_in_ready", 32'(in_ready), 32'd1);
      send_pair(1'b0, 8'd0);
      take_pair(3);

      // Asynchronous reset mid-B load
      fill_random();
      put_prefix(150);
      #3 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      fill_random();
      send_pair(1'b0, 8'd0);
      take_pair(1);

`ifdef LOADER_CHECKSUM_EN
      exp_a = '0;
      exp_b = '0;
      send_pair(1'b0, 8'd0);
      take_pair(1);
      send_pair(1'b0, 8'd1);
`endif

      chk_int("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
